// File: rtl/ram_copy_engine.sv
// Block-copy master for a single-port synchronous RAM: copies length words from
// src_addr to dst_addr (ascending, one word per RD/WR pair) and XORs them into checksum.
module ram_copy_engine #(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] src_addr,
    input  logic [ADDR_WIDTH-1:0] dst_addr,
    input  logic [ADDR_WIDTH:0]   length,
    output logic                  busy,
    output logic                  done,
    output logic [DATA_WIDTH-1:0] checksum,
    output logic [ADDR_WIDTH-1:0] mem_address,
    output logic                  mem_writeOn,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic [1:0]            dbg_state
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        WR   = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam logic [ADDR_WIDTH:0] MAX_LEN = {1'b1, {ADDR_WIDTH{1'b0}}};

    state_t                state;
    logic [ADDR_WIDTH-1:0] src_ptr;
    logic [ADDR_WIDTH-1:0] dst_ptr;
    logic [ADDR_WIDTH:0]   remaining;
    logic [ADDR_WIDTH:0]   sat_len;

    assign sat_len   = (length > MAX_LEN) ? MAX_LEN : length;
    assign dbg_state = state;

    // The word read during RD arrives registered in WR and is forwarded straight to the RAM.
    assign mem_wdata = (state == WR) ? mem_rdata : '0;

    // Handshake: start is a strobe honoured only in IDLE (no queueing); done pulses for one
    // cycle when the command completes; busy covers exactly the RD/WR cycles.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            busy        <= 1'b0;
            done        <= 1'b0;
            checksum    <= '0;
            mem_address <= '0;
            mem_writeOn <= 1'b0;
            src_ptr     <= '0;
            dst_ptr     <= '0;
            remaining   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    mem_writeOn <= 1'b0;
                    if (start) begin
                        src_ptr   <= src_addr;
                        dst_ptr   <= dst_addr;
                        remaining <= sat_len;
                        checksum  <= '0;
                        if (sat_len == '0) begin
                            state <= DONE;
                            done  <= 1'b1;
                        end else begin
                            state       <= RD;
                            busy        <= 1'b1;
                            mem_address <= src_addr;
                        end
                    end
                end
                RD: begin
                    state       <= WR;
                    mem_address <= dst_ptr;
                    mem_writeOn <= 1'b1;
                end
                WR: begin
                    checksum    <= checksum ^ mem_rdata;
                    src_ptr     <= src_ptr + ADDR_WIDTH'(1);
                    dst_ptr     <= dst_ptr + ADDR_WIDTH'(1);
                    remaining   <= remaining - (ADDR_WIDTH + 1)'(1);
                    mem_writeOn <= 1'b0;
                    if (remaining == (ADDR_WIDTH + 1)'(1)) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end else begin
                        state       <= RD;
                        mem_address <= src_ptr + ADDR_WIDTH'(1);
                    end
                end
                DONE: begin
                    done        <= 1'b0;
                    mem_writeOn <= 1'b0;
                    state       <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/ram_copy_engine.md
Name: ram_copy_engine

Overview:
- Initiator-side master for the team's 32x32 synchronous RAM: drives its address, write-enable and write-data lines and consumes its registered read data.
- On a start command, copies a block of words from a source address range to a destination range, one word every 2 cycles.
- Accumulates an XOR checksum of the copied words.
- Sits between control logic (CPU/test sequencer) and the single-port sync RAM.

Parameters:
- ADDR_WIDTH, 5, RAM address width; RAM depth = 2^ADDR_WIDTH.
- DATA_WIDTH, 32, RAM word width.

Ports:
- clk  in  1  system clock; all state changes on rising edge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  command strobe; sampled only in IDLE.
- src_addr  in  ADDR_WIDTH  first source word address.
- dst_addr  in  ADDR_WIDTH  first destination word address.
- length  in  ADDR_WIDTH+1  word count, 0..2^ADDR_WIDTH; larger values saturate to 2^ADDR_WIDTH.
- busy  out  1  high in RD and WR states.
- done  out  1  one-cycle pulse when a command completes.
- checksum  out  DATA_WIDTH  XOR of all words copied by the last command.
- mem_address  out  ADDR_WIDTH  RAM address.
- mem_writeOn  out  1  RAM write enable.
- mem_wdata  out  DATA_WIDTH  RAM write data.
- mem_rdata  in  DATA_WIDTH  RAM registered read data, valid the cycle after the address was presented.

Behaviour:
- Reset, asynchronous and immediate:
  - state = IDLE.
  - busy, done, mem_writeOn = 0.
  - mem_address, mem_wdata, checksum = 0.
  - Internal counters = 0.
- States: IDLE, RD, WR, DONE.
- IDLE:
  - mem_writeOn = 0.
  - On start=1, latch src, dst and saturated length into internal registers, and clear checksum.
  - If the latched length = 0, go to DONE; otherwise go to RD.
- RD:
  - mem_address = src_ptr, mem_writeOn = 0.
  - Next state is WR unconditionally.
- WR:
  - mem_address = dst_ptr, mem_writeOn = 1, mem_wdata = mem_rdata (combinational pass-through of the word read in RD).
  - At the clock edge: checksum ^= mem_rdata; src_ptr and dst_ptr increment by 1, mod 2^ADDR_WIDTH; remaining decrements.
  - If remaining was 1, go to DONE; otherwise go to RD.
- DONE:
  - done = 1 for exactly one cycle; mem_writeOn = 0.
  - Next state is IDLE.
  - checksum holds until the next accepted start.
- Latency:
  - N-word copy: start accepted at edge E0; RD/WR alternate for 2N cycles; done is high in cycle 2N+1 after E0.
  - length=0: done is high in the cycle immediately after E0.
- Wrap-around: pointers roll from 2^ADDR_WIDTH-1 to 0 with no error.
- Overlap: the copy is always ascending. If dst = src+k with k < length, earlier written words are re-read, which replicates the pattern. This is the defined behaviour, not an error.
- start while busy or in DONE: ignored; no queueing.
- Input changes after acceptance: src_addr, dst_addr and length have no effect.
- Reset mid-operation: mem_writeOn drops asynchronously. Words already written remain in RAM; no done pulse is issued.
- Outputs in non-WR states: mem_wdata = 0. mem_address holds its last value in IDLE and DONE.

Test Plan:
- Basic copy: preload RAM[0..3] = 0x11111111, 0x22222222, 0x44444444, 0x88888888; start src=0 dst=8 len=4.
  -> RAM[8..11] equals the source words; done pulses 9 cycles after the start edge; checksum = 0xFFFFFFFF; busy high for 8 cycles.
- Wrap-around: preload RAM[30] = 1, RAM[31] = 2, RAM[0] = 3, RAM[1] = 4; start src=30 dst=10 len=4.
  -> RAM[10..13] = 1, 2, 3, 4; read address sequence 30, 31, 0, 1; checksum = 4.
- Zero length: start src=5 dst=6 len=0.
  -> no mem_writeOn pulse; done one cycle after the start edge; checksum = 0.
- Start while busy: start len=3, then pulse start again with different args during RD.
  -> second command ignored; exactly 3 writes; a single done pulse.
- Overlap: preload RAM[0] = 0xA5, RAM[1] = 0, RAM[2] = 0; start src=0 dst=1 len=2.
  -> RAM[1] = RAM[2] = 0xA5; checksum = 0.
- Reset mid-copy: start len=8; assert reset in the 3rd WR cycle between edges.
  -> mem_writeOn falls immediately; state IDLE; done never pulses; only the first 2 destination words are modified.
